// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings used by both the
// frame reader and the fill/write sequencer, plus the reader state type.
package sdram_pkg;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV
  } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head.
// A word pushed into an empty FIFO shows on head_valid one cycle after the
// push edge. When the last stored word is popped while a new word is pushed,
// the new word goes straight into the head so the stream has no bubble.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic             full,
  output logic [CW-1:0]    free
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;      // words held in mem, excluding the head
  logic [CW-1:0]    occupancy;
  logic             pop_ok;
  logic             load_head;
  logic             ram_rd;
  logic             ram_wr;
  logic             bypass;

  assign occupancy = count + CW'(head_valid);
  assign full      = (occupancy == CW'(DEPTH));
  assign free      = CW'(DEPTH) - occupancy;
  assign pop_ok    = pop && head_valid;
  assign load_head = !head_valid || pop_ok;
  assign ram_rd    = load_head && (count != '0);
  assign bypass    = pop_ok && (count == '0) && push;
  assign ram_wr    = push && !bypass && (!full || pop_ok);

  // Storage array write port.
  // NOTE: the array carries no reset; only pointers and flags need one, and a
  // reset here would turn the RAM into a large bank of flops.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the registered head word.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(ram_wr) - CW'(ram_rd);
      if (ram_rd) begin
        head_data  <= mem[rd_ptr];
        head_valid <= 1'b1;
      end else if (bypass) begin
        head_data  <= push_data;
        head_valid <= 1'b1;
      end else if (pop_ok) begin
        head_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Read-side framebuffer engine: issues CMD_READ bursts that walk the frame
// linearly from BASE_ADDR (wrapping at the frame end), buffers the returned
// beats and streams them to a pixel consumer over valid/ready.
// Optional build macro FRAME_READER_SOF_EN adds o_FrameStart, flagging the
// word read from BASE_ADDR.
module sdram_frame_reader
  import sdram_pkg::*;
#(
  parameter int ADDR_WIDTH        = 22,
  parameter int DATA_WIDTH        = 32,
  parameter int READ_BURST_LENGTH = 8,
  parameter int FRAME_WORDS       = 384000,
  parameter int BASE_ADDR         = 0,
  parameter int FIFO_DEPTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_Enable,
  output logic [1:0]            command,
  output logic [ADDR_WIDTH-1:0] data_address,
  input  logic [DATA_WIDTH-1:0] data_read,
  input  logic                  data_read_valid,
  output logic [DATA_WIDTH-1:0] o_Data,
  output logic                  o_Valid,
  input  logic                  i_Ready,
`ifdef FRAME_READER_SOF_EN
  output logic                  o_FrameStart,
`endif
  output logic                  o_Underflow
);

`ifdef FRAME_READER_SOF_EN
  localparam int FIFO_W = DATA_WIDTH + 1;
`else
  localparam int FIFO_W = DATA_WIDTH;
`endif
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int BEAT_W = $clog2(READ_BURST_LENGTH + 1);

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(READ_BURST_LENGTH);
  localparam logic [ADDR_WIDTH-1:0] FRAME_END = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(READ_BURST_LENGTH - 1);
  localparam logic [CW-1:0]         BURST_SPACE = CW'(READ_BURST_LENGTH);

  reader_state_t         state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_next;
  logic [ADDR_WIDTH-1:0] addr_step, addr_advanced;
  logic [BEAT_W-1:0]     beat_cnt, beat_cnt_next;
  logic [1:0]            command_next;
  logic [ADDR_WIDTH-1:0] data_address_next;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic [CW-1:0]         fifo_free;
  logic [FIFO_W-1:0]     fifo_in;
  logic [FIFO_W-1:0]     fifo_head;
  logic                  can_launch;
  logic                  first_done;

  assign addr_step     = rd_addr + STEP;
  assign addr_advanced = (addr_step == FRAME_END) ? BASE : addr_step;
  assign can_launch    = !fifo_full && (fifo_free >= BURST_SPACE);

  // Beats outside a burst are stale returns from before a reset; drop them.
  assign fifo_push = data_read_valid && (state != ST_IDLE);
  assign fifo_pop  = o_Valid && i_Ready;

`ifdef FRAME_READER_SOF_EN
  // The first beat of a burst is the one seen in REQ; its address is data_address.
  assign fifo_in      = {(state == ST_REQ) && (data_address == BASE), data_read};
  assign o_Data       = fifo_head[DATA_WIDTH-1:0];
  assign o_FrameStart = fifo_head[DATA_WIDTH] && o_Valid;
`else
  assign fifo_in      = data_read;
  assign o_Data       = fifo_head;
`endif

  // Next-state, address and command decode for the burst sequencer.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next        = state;
    rd_addr_next      = rd_addr;
    beat_cnt_next     = beat_cnt;
    command_next      = command;
    data_address_next = data_address;
    case (state)
      ST_IDLE: begin
        if (i_Enable && can_launch) begin
          data_address_next = rd_addr;
          command_next      = CMD_READ;
          state_next        = ST_REQ;
        end
      end
      ST_REQ: begin
        if (data_read_valid) begin
          command_next  = CMD_IDLE;
          beat_cnt_next = BEAT_W'(1);
          if (READ_BURST_LENGTH == 1) begin
            rd_addr_next = addr_advanced;
            state_next   = ST_IDLE;
          end else begin
            state_next   = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (data_read_valid) begin
          if (beat_cnt == LAST_BEAT) begin
            rd_addr_next = addr_advanced;
            state_next   = ST_IDLE;
          end else begin
            beat_cnt_next = beat_cnt + 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Sequencer state and registered controller-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      rd_addr      <= BASE;
      beat_cnt     <= '0;
      command      <= CMD_IDLE;
      data_address <= BASE;
    end else begin
      state        <= state_next;
      rd_addr      <= rd_addr_next;
      beat_cnt     <= beat_cnt_next;
      command      <= command_next;
      data_address <= data_address_next;
    end
  end

  // Sticky underflow: consumer asked for data the buffer could not supply.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_done  <= 1'b0;
      o_Underflow <= 1'b0;
    end else begin
      if (fifo_pop) first_done <= 1'b1;
      if (first_done && !o_Valid && i_Ready) o_Underflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  (fifo_in),
    .pop        (i_Ready),
    .head_data  (fifo_head),
    .head_valid (o_Valid),
    .full       (fifo_full),
    .free       (fifo_free)
  );

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed testbench for sdram_frame_reader with a small 8-beat controller
// model (data equals word address, first beat 3 cycles after CMD_READ) and a
// capturing consumer. The frame is shortened to 16 words to exercise wrap.
module tb_sdram_frame_reader;
  import sdram_pkg::*;

  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_Enable = 1'b0;
  logic [1:0]    command;
  logic [AW-1:0] data_address;
  logic [DW-1:0] data_read;
  logic          data_read_valid;
  logic [DW-1:0] o_Data;
  logic          o_Valid;
  logic          i_Ready = 1'b0;
  logic          o_Underflow;
`ifdef FRAME_READER_SOF_EN
  logic          o_FrameStart;
  bit            sof_q[$];
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [AW-1:0] req_q[$];
  logic [DW-1:0] out_q[$];
  logic [AW-1:0] model_addr;
  bit            gap_mode = 1'b0;
  bit            model_busy;
  int            model_beat;
  int            ready_mode = 0;   // 0 hold, 1 toggle, 2 follow o_Valid
  bit            ready_hold = 1'b0;

  sdram_frame_reader #(
    .ADDR_WIDTH        (AW),
    .DATA_WIDTH        (DW),
    .READ_BURST_LENGTH (8),
    .FRAME_WORDS       (16),
    .BASE_ADDR         (0),
    .FIFO_DEPTH        (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_Enable        (i_Enable),
    .command         (command),
    .data_address    (data_address),
    .data_read       (data_read),
    .data_read_valid (data_read_valid),
    .o_Data          (o_Data),
    .o_Valid         (o_Valid),
    .i_Ready         (i_Ready),
`ifdef FRAME_READER_SOF_EN
    .o_FrameStart    (o_FrameStart),
`endif
    .o_Underflow     (o_Underflow)
  );

  always #5 clk = ~clk;

  // Controller model: one burst per CMD_READ, data equals word address.
  initial begin
    data_read_valid = 1'b0;
    data_read       = '0;
    model_busy      = 1'b0;
    model_beat      = 0;
    forever begin
      @(posedge clk); #1;
      if (command == CMD_READ) begin
        model_busy = 1'b1;
        model_addr = data_address;
        req_q.push_back(data_address);
        repeat (2) @(posedge clk);
        #1;
        for (int b = 0; b < 8; b++) begin
          model_beat      = b;
          data_read       = DW'(model_addr) + DW'(b);
          data_read_valid = 1'b1;
          @(posedge clk); #1;
          data_read_valid = 1'b0;
          if (gap_mode) begin
            @(posedge clk); #1;
          end
        end
        model_busy = 1'b0;
      end
    end
  end

  // Consumer ready driver.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (ready_mode)
        1:       i_Ready = ~i_Ready;
        2:       i_Ready = o_Valid;
        default: i_Ready = ready_hold;
      endcase
    end
  end

  // Capture every accepted word.
  always @(negedge clk) begin
    if (!rst && o_Valid && i_Ready) begin
      out_q.push_back(o_Data);
`ifdef FRAME_READER_SOF_EN
      sof_q.push_back(o_FrameStart);
`endif
    end
  end

  // The free-space check must keep the buffer from ever being pushed while full.
  always @(posedge clk) begin
    if (!rst && dut.fifo_push && dut.fifo_full && !(o_Valid && i_Ready)) begin
      tests_failed++;
      $display("FAIL fifo_overflow: push while full at %0t", $time);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic quiesce_and_reset();
    int cyc = 0;
    i_Enable   = 1'b0;
    ready_mode = 0;
    ready_hold = 1'b0;
    repeat (4) step();
    while ((model_busy || command != CMD_IDLE) && cyc < 200) begin
      step();
      cyc++;
    end
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    gap_mode = 1'b0;
    req_q.delete();
    out_q.delete();
`ifdef FRAME_READER_SOF_EN
    sof_q.delete();
`endif
    step();
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int cyc = 0;
    while (out_q.size() < n && cyc < budget) begin
      step();
      cyc++;
    end
    tests_run++;
    if (out_q.size() < n) begin
      tests_failed++;
      $display("FAIL %s_timeout: got %0d words, need %0d", tag, out_q.size(), n);
    end
  endtask

  task automatic check_words(input int first, input int last, input string tag);
    for (int i = first; i < last && i < out_q.size(); i++) begin
      tests_run++;
      if (out_q[i] !== DW'(i % 16)) begin
        tests_failed++;
        $display("FAIL %s_word%0d: got %0h, expected %0h", tag, i, out_q[i], i % 16);
      end
    end
  endtask

  task automatic check_req(input int idx, input logic [AW-1:0] exp, input string tag);
    tests_run++;
    if (idx >= req_q.size()) begin
      tests_failed++;
      $display("FAIL %s_req%0d: only %0d requests seen", tag, idx, req_q.size());
    end else if (req_q[idx] !== exp) begin
      tests_failed++;
      $display("FAIL %s_req%0d: got %0h, expected %0h", tag, idx, req_q[idx], exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run += 5;
    if (command !== CMD_IDLE) begin
      tests_failed++; $display("FAIL %s_command: got %0d, expected 0", tag, command);
    end
    if (data_address !== '0) begin
      tests_failed++; $display("FAIL %s_address: got %0h, expected 0", tag, data_address);
    end
    if (o_Data !== '0) begin
      tests_failed++; $display("FAIL %s_data: got %0h, expected 0", tag, o_Data);
    end
    if (o_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL %s_valid: got %0b, expected 0", tag, o_Valid);
    end
    if (o_Underflow !== 1'b0) begin
      tests_failed++; $display("FAIL %s_underflow: got %0b, expected 0", tag, o_Underflow);
    end
  endtask

  task automatic test_reset();
    quiesce_and_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_stream_wrap();
    quiesce_and_reset();
    ready_hold = 1'b1;
    i_Enable   = 1'b1;
    wait_words(32, 2000, "stream");
    i_Enable = 1'b0;
    check_req(0, 22'd0, "stream");
    check_req(1, 22'd8, "stream");
    check_req(2, 22'd0, "stream");
    check_req(3, 22'd8, "stream");
    check_words(0, 32, "stream");
`ifdef FRAME_READER_SOF_EN
    for (int i = 0; i < 32 && i < sof_q.size(); i++) begin
      tests_run++;
      if (sof_q[i] !== (i % 16 == 0)) begin
        tests_failed++;
        $display("FAIL sof_word%0d: got %0b, expected %0b", i, sof_q[i], i % 16 == 0);
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    quiesce_and_reset();
    i_Enable = 1'b1;
    repeat (200) step();
    tests_run += 4;
    if (req_q.size() != 4) begin
      tests_failed++; $display("FAIL bp_bursts: got %0d, expected 4", req_q.size());
    end
    if (command !== CMD_IDLE) begin
      tests_failed++; $display("FAIL bp_command: got %0d, expected 0", command);
    end
    if (o_Valid !== 1'b1) begin
      tests_failed++; $display("FAIL bp_valid: got %0b, expected 1", o_Valid);
    end
    if (o_Data !== '0) begin
      tests_failed++; $display("FAIL bp_head: got %0h, expected 0", o_Data);
    end
    ready_hold = 1'b1;
    wait_words(48, 3000, "bp");
    i_Enable = 1'b0;
    check_words(0, 48, "bp");
    check_req(4, 22'd0, "bp");
    check_req(5, 22'd8, "bp");
  endtask

  task automatic test_gaps_toggle();
    quiesce_and_reset();
    gap_mode = 1'b1;
    i_Enable = 1'b1;
    repeat (150) step();
    ready_mode = 1;
    wait_words(56, 4000, "gaps");
    i_Enable = 1'b0;
    check_words(0, 56, "gaps");
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    quiesce_and_reset();
    ready_hold = 1'b1;
    i_Enable   = 1'b1;
    while (!(data_read_valid && model_beat == 3) && cyc < 200) begin
      step();
      cyc++;
    end
    tests_run++;
    if (!(data_read_valid && model_beat == 3)) begin
      tests_failed++; $display("FAIL rstmid_timeout: 4th beat never seen");
    end
    rst      = 1'b1;
    i_Enable = 1'b0;
    step();
    rst = 1'b0;
    check_reset_outputs("rstmid");
    out_q.delete();
    req_q.delete();
    cyc = 0;
    while (model_busy && cyc < 100) begin
      step();
      cyc++;
    end
    repeat (3) step();
    tests_run += 2;
    if (o_Valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_stale_valid: got %0b, expected 0", o_Valid);
    end
    if (out_q.size() != 0) begin
      tests_failed++; $display("FAIL rstmid_stale_words: got %0d, expected 0", out_q.size());
    end
    i_Enable = 1'b1;
    wait_words(8, 500, "rstmid");
    i_Enable = 1'b0;
    check_req(0, 22'd0, "rstmid");
    check_words(0, 8, "rstmid");
  endtask

  task automatic test_enable_mid_burst();
    int cyc = 0;
    quiesce_and_reset();
    ready_mode = 2;
    i_Enable   = 1'b1;
    while (!(data_read_valid && model_beat == 2) && cyc < 200) begin
      step();
      cyc++;
    end
    i_Enable = 1'b0;
    cyc = 0;
    while (model_busy && cyc < 100) begin
      step();
      cyc++;
    end
    repeat (20) step();
    tests_run += 3;
    if (req_q.size() != 1) begin
      tests_failed++; $display("FAIL en_bursts: got %0d, expected 1", req_q.size());
    end
    if (command !== CMD_IDLE) begin
      tests_failed++; $display("FAIL en_command: got %0d, expected 0", command);
    end
    if (out_q.size() != 8) begin
      tests_failed++; $display("FAIL en_words: got %0d, expected 8", out_q.size());
    end
    check_words(0, 8, "en");
    i_Enable = 1'b1;
    wait_words(16, 500, "en");
    i_Enable = 1'b0;
    check_req(1, 22'd8, "en");
    check_words(8, 16, "en");
    tests_run++;
    if (o_Underflow !== 1'b0) begin
      tests_failed++; $display("FAIL en_underflow: got %0b, expected 0", o_Underflow);
    end
  endtask

  initial begin
    test_reset();
    test_stream_wrap();
    test_backpressure();
    test_gaps_toggle();
    test_reset_mid_burst();
    test_enable_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
